// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish at accept.
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opr_1,
  input  logic [XLEN-1:0] opr_2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    negate = ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t          state_r;
  logic [4:0]      cnt_r;
  logic            rem_sel_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic [XLEN-1:0] dvd_r;
  logic [XLEN-1:0] dsr_r;
  logic [XLEN-1:0] rem_r;

  logic            accept_s;
  logic            signed_op_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic            special_s;
  logic [XLEN-1:0] special_out_s;

  logic [XLEN:0]   part_s;
  logic            ge_s;
  logic [XLEN-1:0] rem_nx_s;
  logic [XLEN-1:0] dvd_nx_s;
  logic [XLEN-1:0] result_s;

  // Accept decode: operand magnitudes and the single-cycle special cases.
  always_comb begin
    accept_s      = start && (state_r != CALC);
    signed_op_s   = ~op[0];
    a_neg_s       = signed_op_s & opr_1[XLEN-1];
    b_neg_s       = signed_op_s & opr_2[XLEN-1];
    a_mag_s       = a_neg_s ? negate(opr_1) : opr_1;
    b_mag_s       = b_neg_s ? negate(opr_2) : opr_2;
    div_zero_s    = (opr_2 == ZERO);
    ovf_s         = signed_op_s && (opr_1 == INT_MIN) && (opr_2 == ALL_ONES);
    special_s     = div_zero_s || ovf_s;
    special_out_s = ZERO;
    if (div_zero_s) begin
      special_out_s = op[1] ? opr_1 : ALL_ONES;
    end else begin
      special_out_s = op[1] ? ZERO : INT_MIN;
    end
  end

  // One restoring step; the partial remainder is one bit wider so DIVU/REMU
  // divisors above 2^31 are handled without losing the top remainder bit.
  always_comb begin
    part_s   = {rem_r, dvd_r[XLEN-1]};
    ge_s     = (part_s >= {1'b0, dsr_r});
    rem_nx_s = part_s[XLEN-1:0];
    if (ge_s) begin
      rem_nx_s = part_s[XLEN-1:0] - dsr_r;
    end else begin
      rem_nx_s = part_s[XLEN-1:0];
    end
    dvd_nx_s = {dvd_r[XLEN-2:0], ge_s};
    result_s = ZERO;
    if (rem_sel_r) begin
      result_s = neg_r_r ? negate(rem_nx_s) : rem_nx_s;
    end else begin
      result_s = neg_q_r ? negate(dvd_nx_s) : dvd_nx_s;
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 5'd0;
      rem_sel_r <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      dvd_r     <= ZERO;
      dsr_r     <= ZERO;
      rem_r     <= ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= ZERO;
    end else begin
      case (state_r)
        CALC: begin
          rem_r <= rem_nx_s;
          dvd_r <= dvd_nx_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            out     <= result_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            done    <= 1'b0;
            busy    <= 1'b1;
            state_r <= CALC;
          end
        end
        IDLE, DONE: begin
          if (accept_s) begin
            rem_sel_r <= op[1];
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_r_r   <= a_neg_s;
            dvd_r     <= a_mag_s;
            dsr_r     <= b_mag_s;
            rem_r     <= ZERO;
            cnt_r     <= 5'd0;
            if (special_s) begin
              out     <= special_out_s;
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= DONE;
            end else begin
              done    <= 1'b0;
              busy    <= 1'b1;
              state_r <= CALC;
            end
          end else begin
            done    <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          cnt_r   <= 5'd0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus scoreboard queue,
// with hand sequences for ignored starts, back-to-back issue and mid-run reset.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opr_1;
  logic [31:0] opr_2;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  seq_divider #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .opr_1 (opr_1),
    .opr_2 (opr_2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("busy_done_exclusive", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h expected=none", out);
      end else begin
        check("result", out, exp_q.pop_front());
      end
    end
  end

  // Call aligned before a rising edge; drives one start and scrambles inputs afterwards.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input bit push);
    op    = o;
    opr_1 = a;
    opr_2 = b;
    start = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    opr_1 = $urandom;
    opr_2 = $urandom;
  endtask

  // k counts sample points after the accepting edge; done is expected at k == lat.
  task automatic wait_done(input string name, input int k0, input int lat, input bit exp_busy);
    logic [31:0] held;
    bit stable;
    bit seen;
    stable = 1'b1;
    seen   = 1'b0;
    held   = out;
    for (int k = k0; k <= k0 + 40; k++) begin
      @(negedge clk);
      #1;
      if (k == k0) check({name, "_busy_first"}, {31'd0, busy}, {31'd0, exp_busy});
      if (busy && (out !== held)) stable = 1'b0;
      if (done) begin
        check({name, "_latency"}, k, lat);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done_at_%0d", name, lat);
    end
    check({name, "_out_stable"}, {31'd0, stable}, 32'd1);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[7]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[8]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1};
    vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[12] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[13] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[14] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
    vecs[15] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    opr_1 = 32'd0;
    opr_2 = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_out", out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      wait_done($sformatf("vec%0d", i), 0, vecs[i].special ? 0 : 32, ~vecs[i].special);
    end

    // Start pulsed mid-CALC must be dropped.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (10) @(negedge clk);
    issue(2'b01, 32'd50, 32'd5, 32'd10, 1'b0);
    wait_done("ignore_start", 10, 32, 1'b1);
    begin
      int d0;
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      check("ignore_start_single_done", done_cnt, d0);
    end

    // Start in the DONE cycle is accepted with no idle gap.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_done("b2b_first", 0, 32, 1'b1);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 1'b1);
    wait_done("b2b_second", 0, 32, 1'b1);

    // Reset mid-CALC aborts without a done.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_out", out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1);
    wait_done("after_reset", 0, 32, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
